ram_access_ctrl: RTL and testbench
==================================

# ram_access_ctrl

Synchronous request/response front-end for the single-port RAM with a shared bidirectional data bus and an asynchronous read path. Accepts one read or write request at a time over a valid/ready handshake and drives the RAM's address, write-enable and tri-state data pins. Captures read data into a registered response. An optional clear engine fills the whole array with a constant, one word per cycle.

## Interface
- DATA_WIDTH, 8: RAM word width.
- ADDRESS_WIDTH, 8: RAM address width.
- RAM_DEPTH, 1 << ADDRESS_WIDTH: number of words; sets the clear sweep length.
- CLEAR_VALUE, 0: word written by the clear engine; DATA_WIDTH bits.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (IDLE only).
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDRESS_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata holds read data.
- rsp_rdata  out  DATA_WIDTH  last read word; held until the next read.
- clr_start  in  1  start clear sweep; sampled in IDLE only.
- clr_done  out  1  one-cycle pulse after the last clear write.
- ram_address  out  ADDRESS_WIDTH  RAM address, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_data  inout  DATA_WIDTH  RAM data bus.
  - Driven with the write word when ram_we=1.
  - High-impedance when ram_we=0, so the RAM drives it.

## Operation
- The FSM has four states: IDLE, WRITE, READ, CLEAR.
- Reset values:
  - FSM state IDLE, so req_ready=1.
  - ram_we=0, ram_address=0, internal write register=0.
  - rsp_valid=0, rsp_rdata=0, clr_done=0, clear counter=0.
- IDLE:
  - req_ready=1 and ram_we=0; ram_address keeps its last value.
  - If clr_start=1, go to CLEAR. clr_start wins over req_valid in the same cycle; the request stays pending because req_ready drops.
  - Otherwise, on req_valid=1, register req_addr into ram_address and go to WRITE or READ according to req_write. On a write, also register req_wdata.
- WRITE:
  - req_ready=0, ram_we=1, ram_data driven.
  - The RAM stores the word at the end of this cycle; return to IDLE.
- READ:
  - req_ready=0, ram_we=0, bus released.
  - At the cycle's end, sample ram_data into rsp_rdata, set rsp_valid=1 for exactly one cycle, and return to IDLE.
- CLEAR:
  - req_ready=0, ram_we=1, ram_data=CLEAR_VALUE.
  - ram_address steps 0,1,…,RAM_DEPTH-1, one word per cycle. The counter is ADDRESS_WIDTH+1 bits wide, so there is no wrap-around ambiguity.
  - After address RAM_DEPTH-1 is written, go to IDLE with ram_we=0 and clr_done=1 for one cycle.
- clr_start outside IDLE is ignored; there is no queuing.
- The bus is never driven by both sides: the controller's tri-state enable is derived from the same registered ram_we the RAM sees.
- Reset asserted in any state:
  - Immediately returns all outputs to their reset values and releases the bus.
  - An interrupted clear leaves the RAM partially cleared; no rsp_valid or clr_done is emitted.

## Timing
- A request is accepted on the edge where req_valid=1 and req_ready=1; call it edge N.
- Write: ram_we=1 during cycle N..N+1; the RAM writes at edge N+1; req_ready=1 again after N+1.
- Read: rsp_valid=1 during cycle N+1..N+2. Read latency is 1 cycle from acceptance to response.
- Throughput: one request per 2 cycles. A write followed by a read of the same address returns the new data.
- Clear: ram_we=1 for exactly RAM_DEPTH cycles; clr_done is asserted in the cycle after the last one; total RAM_DEPTH+1 cycles from acceptance.
- Inputs other than during acceptance are don't-care.

## Configuration
- RAM_ACCESS_CTRL_CLEAR_EN defined:
  - The CLEAR state and its counter are compiled in, behaving as above.
- Not defined:
  - clr_start is ignored and clr_done is tied to 0.
  - The FSM has only IDLE/WRITE/READ.
  - Ports are unchanged.

## Test plan
- Reset then idle: after rst_n release, req_ready=1, ram_we=0, ram_data=Z from the controller, rsp_valid=0, rsp_rdata=0x00.
- Write 0xA5 to 0x10, then read 0x10: ram_we high for exactly 1 cycle; rsp_valid pulses 1 cycle after read acceptance with rsp_rdata=0xA5.
- Back-to-back writes to 0x00–0xFF with data=addr^0x3C, then read all 256: every response matches; req_ready is low exactly 1 cycle per request.
- Clear (macro defined) with CLEAR_VALUE=0x00 after filling with 0xFF:
  - clr_start and req_valid asserted together → clear wins.
  - ram_we is high 256 cycles; clr_done pulses once.
  - The pending read of 0x80 then returns 0x00.
- Reset mid-clear at address 0x40: outputs return to reset values immediately; a later read of 0x3F returns 0x00 and a read of 0x41 returns 0xFF; no clr_done.
- Macro undefined: clr_start pulse in IDLE → no state change, clr_done stays 0, the next request is accepted the same cycle.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Request/response front-end for a single-port RAM that has a shared
//   bidirectional data bus and an asynchronous read path. It accepts one read
//   or write at a time over a valid/ready handshake. It drives the RAM
//   address, write-enable and tri-state data pins, and it registers read data
//   into a one-cycle response.
//
//   Optional feature macro: RAM_ACCESS_CTRL_CLEAR_EN
//     When defined, a clear engine fills the whole array with CLEAR_VALUE,
//     one word per cycle. When undefined, clr_start is ignored and clr_done
//     is held at 0.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     req_valid    request present
//     req_ready    request can be accepted (IDLE only)
//     req_write    1 = write, 0 = read
//     req_addr     request address
//     req_wdata    write data
//     rsp_valid    one-cycle pulse when rsp_rdata is updated with read data
//     rsp_rdata    last read word, held until the next read
//     clr_start    start a clear sweep (sampled in IDLE only)
//     clr_done     one-cycle pulse after the last clear write
//     ram_address  registered RAM address
//     ram_we       registered RAM write enable
//     ram_data     RAM data bus; driven only while ram_we = 1
module ram_access_ctrl #(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter int unsigned           ADDRESS_WIDTH = 8,
  parameter int unsigned           RAM_DEPTH     = 1 << ADDRESS_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  input  logic                     clr_start,
  output logic                     clr_done,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_we,
  inout  logic [DATA_WIDTH-1:0]    ram_data
);

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
  typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
`endif

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] addr_next;
  logic                     we_next;
  logic [DATA_WIDTH-1:0]    wdata, wdata_next;
  logic                     rsp_valid_next;
  logic [DATA_WIDTH-1:0]    rsp_rdata_next;

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
  // One bit wider than the address so the sweep's last index RAM_DEPTH-1
  // can be compared without any wrap-around ambiguity.
  localparam logic [ADDRESS_WIDTH:0] CNT_LAST = (ADDRESS_WIDTH+1)'(RAM_DEPTH - 1);
  logic [ADDRESS_WIDTH:0] cnt, cnt_next, cnt_inc;
  logic                   clr_done_next;
  assign cnt_inc = cnt + 1'b1;
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
  assign clr_done         = 1'b0;
`endif

  assign req_ready = (state == IDLE);

  // The bus enable is the same registered ram_we that the RAM sees, so the
  // two sides never drive the bus at the same time. During a clear, the
  // write register holds CLEAR_VALUE.
  assign ram_data = ram_we ? wdata : 'z;

  always_comb begin
    state_next     = state;
    addr_next      = ram_address;
    we_next        = 1'b0;
    wdata_next     = wdata;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata;
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
    cnt_next       = cnt;
    clr_done_next  = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
        if (clr_start) begin
          state_next = CLEAR;
          cnt_next   = '0;
          addr_next  = '0;
          we_next    = 1'b1;
          wdata_next = CLEAR_VALUE;
        end else
`endif
        if (req_valid) begin
          addr_next = req_addr;
          if (req_write) begin
            state_next = WRITE;
            we_next    = 1'b1;
            wdata_next = req_wdata;
          end else begin
            state_next = READ;
          end
        end
      end
      WRITE: state_next = IDLE;
      READ: begin
        state_next     = IDLE;
        rsp_valid_next = 1'b1;
        rsp_rdata_next = ram_data;
      end
`ifdef RAM_ACCESS_CTRL_CLEAR_EN
      CLEAR: begin
        if (cnt == CNT_LAST) begin
          state_next    = IDLE;
          clr_done_next = 1'b1;
        end else begin
          cnt_next  = cnt_inc;
          addr_next = cnt_inc[ADDRESS_WIDTH-1:0];
          we_next   = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ram_address <= '0;
      ram_we      <= 1'b0;
      wdata       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state       <= state_next;
      ram_address <= addr_next;
      ram_we      <= we_next;
      wdata       <= wdata_next;
      rsp_valid   <= rsp_valid_next;
      rsp_rdata   <= rsp_rdata_next;
    end
  end

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      clr_done <= clr_done_next;
    end
  end
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
//   Bench for ram_access_ctrl. It contains a behavioural single-port RAM with
//   an asynchronous read and a synchronous write, plus a reference array that
//   holds the contents the RAM should have. Request timing and response data
//   are checked against these after each step.
module tb_ram_access_ctrl;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;
  localparam logic [DW-1:0] CLR = 8'h00;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          clr_start, clr_done;
  logic [AW-1:0] ram_address;
  logic          ram_we;
  wire  [DW-1:0] ram_data;

  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] model [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ram_data = ram_we ? 'z : mem[ram_address];
  always @(posedge clk) if (ram_we) mem[ram_address] <= ram_data;

  ram_access_ctrl #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .RAM_DEPTH(DEPTH), .CLEAR_VALUE(CLR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clr_start(clr_start), .clr_done(clr_done),
    .ram_address(ram_address), .ram_we(ram_we), .ram_data(ram_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_idle_inputs();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    check("wr_ready_before", 32'(req_ready), 32'(1));
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    tick();
    scramble_idle_inputs();
    model[a] = d;
    check("wr_we_high",  32'(ram_we),      32'(1));
    check("wr_ready_lo", 32'(req_ready),   32'(0));
    check("wr_addr",     32'(ram_address), 32'(a));
    check("wr_bus",      32'(ram_data),    32'(d));
    check("wr_no_rsp",   32'(rsp_valid),   32'(0));
    tick();
    check("wr_we_low",   32'(ram_we),      32'(0));
    check("wr_ready_hi", 32'(req_ready),   32'(1));
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = DW'($urandom);
    tick();
    scramble_idle_inputs();
    check("rd_ready_lo", 32'(req_ready),   32'(0));
    check("rd_we_low",   32'(ram_we),      32'(0));
    check("rd_addr",     32'(ram_address), 32'(a));
    check("rd_no_rsp",   32'(rsp_valid),   32'(0));
    tick();
    check("rd_rsp_valid", 32'(rsp_valid), 32'(1));
    check("rd_rsp_data",  32'(rsp_rdata), 32'(model[a]));
    check("rd_ready_hi",  32'(req_ready), 32'(1));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, we_cnt, done_cnt;
    logic [AW-1:0] a;

    // Reset and idle
    rst_n = 1'b0; clr_start = 1'b0;
    scramble_idle_inputs();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_ready",     32'(req_ready),   32'(1));
    check("rst_we",        32'(ram_we),      32'(0));
    check("rst_addr",      32'(ram_address), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid),   32'(0));
    check("rst_rsp_data",  32'(rsp_rdata),   32'(0));
    check("rst_clr_done",  32'(clr_done),    32'(0));

    // Single write, then a read of the same address
    do_write(8'h10, 8'hA5);
    do_read(8'h10);
    tick();
    check("rsp_pulse_one_cycle", 32'(rsp_valid), 32'(0));
    check("rsp_data_held",       32'(rsp_rdata), 32'(8'hA5));

    // Back-to-back fill, then a full read-back
    for (int i = 0; i < int'(DEPTH); i++) do_write(AW'(i), DW'(i) ^ 8'h3C);
    for (int i = 0; i < int'(DEPTH); i++) do_read(AW'(i));

    // Random mix of reads and writes with idle gaps
    for (int i = 0; i < 300; i++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom));
      else                           do_read(a);
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check("rnd_idle_ready", 32'(req_ready), 32'(1));
        check("rnd_idle_done",  32'(clr_done),  32'(0));
      end
    end

`ifdef RAM_ACCESS_CTRL_CLEAR_EN
    // Clear wins over a simultaneous read; the read stays pending
    for (int i = 0; i < int'(DEPTH); i++) do_write(AW'(i), 8'hFF);
    clr_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h80;
    tick();
    clr_start = 1'b0;
    check("clr_ready_lo", 32'(req_ready),   32'(0));
    check("clr_we",       32'(ram_we),      32'(1));
    check("clr_addr0",    32'(ram_address), 32'(0));
    check("clr_bus",      32'(ram_data),    32'(CLR));
    we_cnt = 1; done_cnt = 0; cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      tick();
      cyc++;
      if (clr_done) done_cnt++;
      if (ram_we) begin
        check("clr_addr_step", 32'(ram_address), 32'(we_cnt));
        we_cnt++;
      end
    end
    check("clr_done_latency", 32'(cyc),      32'(DEPTH));
    check("clr_we_cycles",    32'(we_cnt),   32'(DEPTH));
    check("clr_done_seen",    32'(done_cnt), 32'(1));
    for (int i = 0; i < int'(DEPTH); i++) model[i] = CLR;
    tick();
    req_valid = 1'b0;
    check("clr_done_pulse", 32'(clr_done),    32'(0));
    check("pend_rd_accept", 32'(req_ready),   32'(0));
    check("pend_rd_addr",   32'(ram_address), 32'(8'h80));
    tick();
    check("pend_rd_valid", 32'(rsp_valid), 32'(1));
    check("pend_rd_data",  32'(rsp_rdata), 32'(CLR));
    do_read(8'h00);
    do_read(8'hFF);

    // clr_start outside IDLE is ignored
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05;
    tick();
    req_valid = 1'b0; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check("busy_clr_ignored_we",  32'(ram_we),    32'(0));
    check("busy_clr_ready",       32'(req_ready), 32'(1));
    check("busy_clr_rsp",         32'(rsp_valid), 32'(1));
    tick();
    check("busy_clr_still_idle",  32'(ram_we),    32'(0));

    // Reset in the middle of a clear
    for (int i = 0; i < int'(DEPTH); i++) do_write(AW'(i), 8'hFF);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    cyc = 0;
    while (ram_address != 8'h40 && cyc < 300) begin
      tick();
      cyc++;
    end
    check("midclr_reached_0x40", 32'(ram_address == 8'h40 && ram_we), 32'(1));
    rst_n = 1'b0;
    #1;
    check("midclr_rst_we",    32'(ram_we),      32'(0));
    check("midclr_rst_addr",  32'(ram_address), 32'(0));
    check("midclr_rst_ready", 32'(req_ready),   32'(1));
    check("midclr_rst_done",  32'(clr_done),    32'(0));
    for (int i = 0; i < 8'h40; i++) model[i] = CLR;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("midclr_no_done", 32'(clr_done), 32'(0));
    do_read(8'h3F);
    do_read(8'h40);
    do_read(8'h41);
    do_read(8'h00);
`else
    // Without the clear engine, clr_start has no effect
    clr_start = 1'b1;
    tick();
    check("noclr_ready", 32'(req_ready), 32'(1));
    check("noclr_we",    32'(ram_we),    32'(0));
    check("noclr_done",  32'(clr_done),  32'(0));
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h22; req_wdata = 8'h5A;
    tick();
    clr_start = 1'b0;
    scramble_idle_inputs();
    model[8'h22] = 8'h5A;
    check("noclr_accept_we",   32'(ram_we),      32'(1));
    check("noclr_accept_addr", 32'(ram_address), 32'(8'h22));
    check("noclr_accept_rdy",  32'(req_ready),   32'(0));
    check("noclr_done2",       32'(clr_done),    32'(0));
    tick();
    do_read(8'h22);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
